// File: rtl/uart_memory.sv
// Memory back-end that forwards 32-bit read/write commands as UART request frames
// and collects 4-byte read responses from the host on the same link.
module uart_memory #(
    parameter int FMAX_MHz  = 27,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic        cmd_write,
    output logic        cmd_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CLKS_PER_BIT = FMAX_MHz * 1000000 / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // Handshake: a command transfers on a rising edge where cmd_start and cmd_ready
    // are both 1; cmd_start with cmd_ready low is dropped. rdata_valid is a
    // single-cycle pulse with no back-pressure, and rdata holds until the next read.

    typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Transaction FSM state, visible for checkers by hierarchical reference.
    state_t     state;
    rx_state_t  rx_state;

    // Latched command
    logic        cmd_write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wmask_q;

    // Transmitter
    logic [3:0]       byte_idx;
    logic [3:0]       tx_bit;
    logic [CNT_W-1:0] tx_cnt;
    logic [103:0]     frame;
    logic [7:0]       tx_byte;
    logic [3:0]       last_idx;

    // Receiver
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_byte_ok;
    logic [1:0]       rx_count;
    logic [23:0]      rx_acc;

    assign frame    = {wmask_q, wdata_q, addr_q, (cmd_write_q ? 8'h57 : 8'h52)};
    assign tx_byte  = frame[{byte_idx, 3'b000} +: 8];
    assign last_idx = cmd_write_q ? 4'd12 : 4'd4;

    // A byte is accepted on the clock its stop bit is seen high at bit centre.
    assign rx_byte_ok = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at half a bit means the falling edge was a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            uart_tx     <= 1'b1;
            cmd_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            byte_idx    <= '0;
            tx_bit      <= '0;
            tx_cnt      <= '0;
            rx_count    <= '0;
            rx_acc      <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (cmd_start && cmd_ready) begin
                        cmd_write_q <= cmd_write;
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        wmask_q     <= wmask;
                        cmd_ready   <= 1'b0;
                        state       <= SEND;
                        uart_tx     <= 1'b0;
                        byte_idx    <= '0;
                        tx_bit      <= '0;
                        tx_cnt      <= '0;
                    end
                end
                SEND: begin
                    // tx_bit 0 is the start bit, 1..8 the data bits, 9 the stop bit.
                    if (tx_cnt != BIT_LAST) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            if (byte_idx == last_idx) begin
                                uart_tx <= 1'b1;
                                if (cmd_write_q) begin
                                    state     <= IDLE;
                                    cmd_ready <= 1'b1;
                                end else begin
                                    state    <= RECV;
                                    rx_count <= '0;
                                end
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                tx_bit   <= '0;
                                uart_tx  <= 1'b0;
                            end
                        end else begin
                            tx_bit  <= tx_bit + 1'b1;
                            uart_tx <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                        end
                    end
                end
                RECV: begin
                    if (rx_byte_ok) begin
                        rx_acc <= {rx_shift, rx_acc[23:8]};
                        if (rx_count == 2'd3) begin
                            rdata       <= {rx_shift, rx_acc};
                            rdata_valid <= 1'b1;
                            cmd_ready   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            rx_count <= rx_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    uart_tx   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_memory.sv
// Directed bench for uart_memory at 10 clocks per bit: frame capture on uart_tx,
// host reply driver on uart_rx, and a monitor for the rdata_valid pulse.
module tb_uart_memory;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic        cmd_write;
    logic        cmd_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        uart_rx;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    int          valid_cnt = 0;
    logic [31:0] v_rdata = '0;
    logic        v_ready = 1'b0;
    logic        post_pend = 1'b0;
    logic        post_tx = 1'b1;
    logic        post_ready = 1'b1;

    uart_memory #(
        .FMAX_MHz (1),
        .BAUD_RATE(100000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_start  (cmd_start),
        .cmd_write  (cmd_write),
        .cmd_ready  (cmd_ready),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    // Records each rdata_valid cycle and the uart_tx/cmd_ready values one cycle later.
    always @(negedge clk) begin
        if (post_pend) begin
            post_tx    <= uart_tx;
            post_ready <= cmd_ready;
        end
        post_pend <= rdata_valid;
        if (rdata_valid) begin
            valid_cnt <= valid_cnt + 1;
            v_rdata   <= rdata;
            v_ready   <= cmd_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] wm);
        exp_q.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) exp_q.push_back(a[8*i +: 8]);
        if (wr) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(wd[8*i +: 8]);
            for (int i = 0; i < 4; i++) exp_q.push_back(wm[8*i +: 8]);
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] wm);
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'h1);
        cmd_write = wr;
        addr      = a;
        wdata     = wd;
        wmask     = wm;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check("cmd_ready_after_accept", 32'(cmd_ready), 32'h0);
    endtask

    // Called on a negedge; returns on the negedge at the stop-bit centre.
    task automatic recv_byte(output logic [7:0] b, output int gap);
        int n;
        n = 0;
        b = '0;
        while (uart_tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        if (uart_tx !== 1'b0) begin
            check("tx_start_timeout", 32'(uart_tx), 32'h0);
            return;
        end
        repeat (CPB / 2 - 1) @(negedge clk);
        check("tx_start_bit", 32'(uart_tx), 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", 32'(uart_tx), 32'h1);
    endtask

    // Start bit of each byte from gap_from onwards must follow the previous stop with no idle.
    task automatic recv_frame(input int n, input int gap_from);
        logic [7:0] b;
        logic [7:0] e;
        int         gap;
        for (int i = 0; i < n; i++) begin
            recv_byte(b, gap);
            e = exp_q.pop_front();
            check($sformatf("tx_byte[%0d]", i), 32'(b), 32'(e));
            if (i >= gap_from) check($sformatf("tx_gap[%0d]", i), 32'(gap), 32'd6);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int base;
        int n;

        rst_n     = 1'b0;
        cmd_start = 1'b0;
        cmd_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        wmask     = '0;
        uart_rx   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_uart_tx", 32'(uart_tx), 32'h1);
        check("reset_cmd_ready", 32'(cmd_ready), 32'h1);
        check("reset_rdata_valid", 32'(rdata_valid), 32'h0);
        check("reset_rdata", rdata, 32'h0);

        // Plain read
        base = valid_cnt;
        push_frame(1'b0, 32'h0000_1004, 32'h0, 32'h0);
        issue_cmd(1'b0, 32'h0000_1004, 32'h0, 32'h0);
        recv_frame(5, 1);
        send_word(32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        check("read_valid_pulses", 32'(valid_cnt - base), 32'd1);
        check("read_rdata_at_valid", v_rdata, 32'hDEAD_BEEF);
        check("read_ready_at_valid", 32'(v_ready), 32'h1);
        check("read_rdata_held", rdata, 32'hDEAD_BEEF);

        // Write: no response, ready returns at the end of the last stop bit
        base = valid_cnt;
        push_frame(1'b1, 32'h0000_0020, 32'h1122_3344, 32'h0000_FFFF);
        issue_cmd(1'b1, 32'h0000_0020, 32'h1122_3344, 32'h0000_FFFF);
        recv_frame(13, 1);
        wait_ready(n);
        check("write_ready_delay", 32'(n), 32'd6);
        repeat (20) @(negedge clk);
        check("write_no_valid", 32'(valid_cnt - base), 32'd0);
        check("write_rdata_unchanged", rdata, 32'hDEAD_BEEF);
        check("write_tx_idle", 32'(uart_tx), 32'h1);

        // Back-to-back: write held on cmd_start while busy, accepted in the valid cycle
        base = valid_cnt;
        push_frame(1'b0, 32'h0000_0ABC, 32'h0, 32'h0);
        issue_cmd(1'b0, 32'h0000_0ABC, 32'h0, 32'h0);
        cmd_write = 1'b1;
        addr      = 32'h0000_0040;
        wdata     = 32'hCAFE_F00D;
        wmask     = 32'hFFFF_FFFF;
        cmd_start = 1'b1;
        recv_frame(5, 1);
        send_word(32'h0403_0201);
        cmd_start = 1'b0;
        check("b2b_valid_pulses", 32'(valid_cnt - base), 32'd1);
        check("b2b_rdata_at_valid", v_rdata, 32'h0403_0201);
        check("b2b_ready_at_valid", 32'(v_ready), 32'h1);
        check("b2b_tx_start_next", 32'(post_tx), 32'h0);
        check("b2b_ready_next", 32'(post_ready), 32'h0);
        push_frame(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        recv_frame(13, 2);
        wait_ready(n);
        check("b2b_write_done", 32'(cmd_ready), 32'h1);
        check("b2b_write_no_valid", 32'(valid_cnt - base), 32'd1);
        check("b2b_rdata_held", rdata, 32'h0403_0201);

        // Glitch and framing error during RECV are ignored
        base = valid_cnt;
        push_frame(1'b0, 32'h0000_0100, 32'h0, 32'h0);
        issue_cmd(1'b0, 32'h0000_0100, 32'h0, 32'h0);
        recv_frame(5, 1);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        send_byte(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        check("err_no_early_valid", 32'(valid_cnt - base), 32'd0);
        check("err_still_busy", 32'(cmd_ready), 32'h0);
        send_word(32'h1234_5678);
        repeat (3) @(negedge clk);
        check("err_valid_pulses", 32'(valid_cnt - base), 32'd1);
        check("err_rdata", rdata, 32'h1234_5678);

        // Reset in the middle of a request frame
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h00);
        issue_cmd(1'b0, 32'h0000_2000, 32'h0, 32'h0);
        recv_frame(2, 1);
        repeat (8) @(negedge clk);
        check("mid_frame_tx_low", 32'(uart_tx), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_uart_tx", 32'(uart_tx), 32'h1);
        check("mid_reset_cmd_ready", 32'(cmd_ready), 32'h1);
        check("mid_reset_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_tx_idle", 32'(uart_tx), 32'h1);
        base = valid_cnt;
        push_frame(1'b0, 32'h0000_3008, 32'h0, 32'h0);
        issue_cmd(1'b0, 32'h0000_3008, 32'h0, 32'h0);
        recv_frame(5, 1);
        send_word(32'h1122_3344);
        repeat (3) @(negedge clk);
        check("post_reset_valid_pulses", 32'(valid_cnt - base), 32'd1);
        check("post_reset_rdata", rdata, 32'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
